// File: rtl/token_encoder.sv
// Dictionary encoder: looks up each accepted instruction word in a SIZE-entry
// dictionary, one entry per cycle from index 0, and emits a hit token or a raw miss.
module token_encoder #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 64,
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hit,
  output logic [IDX_W-1:0]  out_token,
  output logic [WIDTH-1:0]  out_data,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              hit_q, hit_d;
  logic [IDX_W-1:0]  token_q, token_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       hit_count_q, hit_count_d;
  logic [15:0]       miss_count_q, miss_count_d;
  logic [WIDTH-1:0]  entry_q [SIZE];
  logic [WIDTH-1:0]  entry_d [SIZE];
  logic [SIZE-1:0]   entry_vld_q, entry_vld_d;

  logic              wr_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic              match_s;
  logic              last_s;
  logic              wr_addr_unused_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Writes are blocked while reset is held so a reset cannot leave a valid entry.
  assign wr_s             = wr_en & reset_n;
  assign wr_idx_s         = wr_addr[IDX_W+1:2];
  assign wr_addr_unused_s = ^{wr_addr[WIDTH-1:IDX_W+2], wr_addr[1:0]};

  // Compare sees pre-edge entry contents, so a same-cycle write cannot affect it.
  assign match_s = entry_vld_q[idx_q] && (entry_q[idx_q] == word_q);
  assign last_s  = (idx_q == IDX_W'(SIZE - 1));

  assign in_ready   = (state_q == IDLE) & reset_n;
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_hit    = hit_q;
  assign out_token  = token_q;
  assign out_data   = word_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Dictionary next-state: single write port, any state.
  always_comb begin
    entry_d     = entry_q;
    entry_vld_d = entry_vld_q;
    if (wr_s) begin
      entry_d[wr_idx_s]     = wr_data;
      entry_vld_d[wr_idx_s] = 1'b1;
    end else begin
      entry_vld_d = entry_vld_q;
    end
  end

  // Search FSM next-state and result/counter updates.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    hit_d        = hit_q;
    token_d      = token_q;
    out_valid_d  = out_valid_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          idx_d   = '0;
          state_d = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (match_s) begin
          hit_d       = 1'b1;
          token_d     = idx_q;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end else if (last_s) begin
          hit_d       = 1'b0;
          token_d     = '0;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (hit_q) begin
            hit_count_d = sat_inc(hit_count_q);
          end else begin
            miss_count_d = sat_inc(miss_count_q);
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Control, result and valid-bit registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      word_q       <= '0;
      hit_q        <= 1'b0;
      token_q      <= '0;
      out_valid_q  <= 1'b0;
      hit_count_q  <= 16'd0;
      miss_count_q <= 16'd0;
      entry_vld_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      hit_q        <= hit_d;
      token_q      <= token_d;
      out_valid_q  <= out_valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      entry_vld_q  <= entry_vld_d;
    end
  end

  // Entry values need no reset; the valid bits gate every match.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_token_encoder.sv
// Directed bench for token_encoder: hand-computed latencies, tokens and counts.
module tb_token_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_hit;
  logic [5:0]  out_token;
  logic [31:0] out_data;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks   = 0;
  int failures = 0;
  int since_acc = 0;

  token_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hit   (out_hit),
    .out_token (out_token),
    .out_data  (out_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    since_acc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic dict_write(input logic [31:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic start(input logic [31:0] word);
    in_valid = 1'b1;
    in_data  = word;
    tick();
    in_valid  = 1'b0;
    since_acc = 0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat, input logic exp_hit,
                          input logic [5:0] exp_tok, input logic [31:0] exp_data);
    while (!out_valid && since_acc < 300) tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_lat"}, 32'(since_acc), 32'(exp_lat));
    chk({tag, "_hit"}, 32'(out_hit), 32'(exp_hit));
    chk({tag, "_token"}, 32'(out_token), 32'(exp_tok));
    chk({tag, "_data"}, out_data, exp_data);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 32'd0;
    wr_data   = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_counts", {hit_count, miss_count}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Entry 2 hit, then held result with stalled downstream
    dict_write(32'h0000_0008, 32'h0000_0013);
    start(32'h0000_0013);
    chk("srch_busy", 32'(busy), 32'd1);
    chk("srch_in_ready", 32'(in_ready), 32'd0);
    wait_out("e2", 3, 1'b1, 6'd2, 32'h0000_0013);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_tok", {26'd0, out_token}, 32'd2);
    chk("stall_hit", 32'(out_hit), 32'd1);
    chk("stall_data", out_data, 32'h0000_0013);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    handshake();
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_hit_count", 32'(hit_count), 32'd1);

    // Empty dictionary miss
    do_reset();
    start(32'hDEAD_BEEF);
    wait_out("miss", 64, 1'b0, 6'd0, 32'hDEAD_BEEF);
    handshake();
    chk("miss_count", {hit_count, miss_count}, 32'h0000_0001);

    // Lowest duplicate index wins
    dict_write(32'h0000_0024, 32'hAAAA_5555);
    dict_write(32'h0000_0014, 32'hAAAA_5555);
    start(32'hAAAA_5555);
    wait_out("dup", 6, 1'b1, 6'd5, 32'hAAAA_5555);
    handshake();
    chk("dup_counts", {hit_count, miss_count}, 32'h0001_0001);

    // Last entry via address with ignored upper and low bits
    dict_write(32'hABCD_01FF, 32'hCAFE_F00D);
    start(32'hCAFE_F00D);
    wait_out("e63", 64, 1'b1, 6'd63, 32'hCAFE_F00D);
    handshake();

    // Reset during search of entry 20 abandons the word and clears the dictionary
    dict_write(32'h0000_0078, 32'h1111_2222);
    start(32'h1111_2222);
    for (int i = 0; i < 20; i++) tick();
    reset_n = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("abort_no_valid", 32'(out_valid), 32'd0);
    start(32'h1111_2222);
    wait_out("abort_re", 64, 1'b0, 6'd0, 32'h1111_2222);
    handshake();

    // Write ahead of the search index is found
    start(32'h1234_5678);
    tick();
    tick();
    tick();
    dict_write(32'h0000_0028, 32'h1234_5678);
    wait_out("ahead", 11, 1'b1, 6'd10, 32'h1234_5678);
    handshake();

    // Write behind the search index is missed
    start(32'h8765_4321);
    for (int i = 0; i < 8; i++) tick();
    dict_write(32'h0000_0014, 32'h8765_4321);
    wait_out("behind", 64, 1'b0, 6'd0, 32'h8765_4321);
    handshake();

    // Write to the entry being compared this cycle does not affect that compare
    start(32'h0F0F_0F0F);
    for (int i = 0; i < 4; i++) tick();
    dict_write(32'h0000_0010, 32'h0F0F_0F0F);
    wait_out("same", 64, 1'b0, 6'd0, 32'h0F0F_0F0F);
    handshake();
    chk("final_counts", {hit_count, miss_count}, 32'h0001_0003);

    // Writes while reset is held are dropped
    reset_n = 1'b0;
    dict_write(32'h0000_001C, 32'h5A5A_A5A5);
    reset_n = 1'b1;
    tick();
    start(32'h5A5A_A5A5);
    wait_out("rst_wr", 64, 1'b0, 6'd0, 32'h5A5A_A5A5);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/token_encoder.md
TOKEN_ENCODER -- requirements
Module: token_encoder

Interface
REQ-001 Parameter WIDTH, default 32, instruction/entry word width in bits.
REQ-002 Parameter SIZE, default 64, number of dictionary entries (power of two).
REQ-003 Parameter IDX_W, default 6, token index width; SHALL equal log2(SIZE).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 in_valid  input  1  upstream has an instruction word on in_data.
REQ-007 in_ready  output  1  block can accept a word.
REQ-008 in_data  input  WIDTH  raw instruction word to encode.
REQ-009 out_valid  output  1  encode result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_hit  output  1  1 = word found in dictionary, 0 = miss (raw passthrough).
REQ-012 out_token  output  IDX_W  matching entry index on hit; 0 on miss.
REQ-013 out_data  output  WIDTH  latched raw word (valid on hit and miss).
REQ-014 wr_en  input  1  dictionary write strobe.
REQ-015 wr_addr  input  WIDTH  byte address; entry index = wr_addr[IDX_W+1:2] (word aligned); wr_addr[1:0] and bits above IDX_W+1 ignored.
REQ-016 wr_data  input  WIDTH  dictionary entry value.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 hit_count, miss_count  output  16 each  saturating counts of emitted hits/misses.

Function
REQ-019 Dictionary SHALL be SIZE x WIDTH registers plus one valid bit per entry; only entries with valid=1 can match.
REQ-020 wr_en=1 SHALL write wr_data to the indexed entry and set its valid bit at the clock edge, in any state.
REQ-021 FSM states SHALL be IDLE, SEARCH, EMIT; in_ready = (state==IDLE).
REQ-022 IDLE: in_valid & in_ready at an edge -> latch in_data, search index = 0, go to SEARCH.
REQ-023 SEARCH: each cycle compare entry[index] (value before that edge) with the latched word; one entry per cycle, ascending from 0.
REQ-024 SEARCH match at index k -> go to EMIT with out_hit=1, out_token=k; the lowest matching index wins.
REQ-025 SEARCH no match and index==SIZE-1 -> go to EMIT with out_hit=0, out_token=0; otherwise index increments.
REQ-026 Latency: hit at index k -> out_valid high k+1 cycles after the accepting edge; miss -> SIZE cycles.
REQ-027 EMIT: out_valid=1; out_hit, out_token, out_data SHALL remain stable until out_valid & out_ready at an edge, then IDLE.
REQ-028 A write to an entry in the same cycle it is compared SHALL NOT affect that compare; later compares see the new value.
REQ-029 hit_count/miss_count SHALL increment on each EMIT handshake with out_hit=1/0, saturating at 16'hFFFF.
REQ-030 out_valid SHALL be 0 in IDLE and SEARCH; no back-to-back accept: a new word is accepted no earlier than the edge after the output handshake.

Reset
REQ-031 reset_n=0 at an edge SHALL: state=IDLE, clear all valid bits, out_valid=0, out_hit=0, out_token=0, out_data=0, hit_count=0, miss_count=0; entry values need not be cleared.
REQ-032 in_ready SHALL be 0 while reset_n=0 and 1 on the first cycle after release.
REQ-033 Reset during SEARCH or EMIT SHALL abandon the word; no out_valid is produced for it.
REQ-034 wr_en SHALL be ignored while reset_n=0.

Verification
REQ-035 After reset, write 32'h00000013 to wr_addr 0x8 (entry 2); send 32'h00000013 -> out_hit=1, out_token=2, out_valid 3 cycles after accept.
REQ-036 Empty dictionary, send 32'hDEADBEEF -> out_hit=0, out_token=0, out_data=32'hDEADBEEF after 64 cycles; miss_count=1.
REQ-037 Same value in entries 5 and 9, send it -> out_token=5.
REQ-038 Hit result with out_ready=0 for 10 cycles -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle, hit_count=1.
REQ-039 Assert reset_n=0 during SEARCH of entry 20 -> no out_valid, busy=0, subsequent search of previously written word misses.
REQ-040 During SEARCH, write the searched word to an entry index above the current search index -> hit on that entry; write to index already passed -> miss.
